// File: rtl/systolic_pkg.sv
// Shared sizing helpers and the default matrix type for the systolic array front end.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ARRAY_W    = 4;
  localparam int DEF_ARRAY_L    = 4;

  function automatic int n_elems(input int w, input int l);
    return w * l;
  endfunction

  // Element index width; a 1x1 matrix still gets a 1-bit counter.
  function automatic int idx_width(input int w, input int l);
    int n;
    n = w * l;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [0:DEF_ARRAY_W-1][0:DEF_ARRAY_L-1][DEF_DATA_WIDTH-1:0] matrix_t;

endpackage

// File: rtl/matrix_loader.sv
// Assembles a row-major element stream into a full matrix, double buffered:
// the next frame fills while the previous one is held on mat_data.
module matrix_loader
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           in_valid,
  input  logic [DATA_WIDTH-1:0]                          in_data,
  input  logic                                           in_last,
  output logic                                           in_ready,
  output logic [0:ARRAY_W-1][0:ARRAY_L-1][DATA_WIDTH-1:0] mat_data,
  output logic                                           mat_valid,
  input  logic                                           mat_ready,
  output logic                                           frame_err
);

  localparam int N     = n_elems(ARRAY_W, ARRAY_L);
  localparam int IDX_W = idx_width(ARRAY_W, ARRAY_L);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  logic [DATA_WIDTH-1:0] fill_mem [N];
  logic [IDX_W-1:0]      idx_p0;
  logic                  fill_full_p0;
  logic                  acc;
  logic                  at_end;
  logic                  early_last;
  logic                  xfer;

  assign in_ready   = !fill_full_p0;
  assign acc        = in_valid && in_ready;
  assign at_end     = (idx_p0 == LAST_IDX);
  assign early_last = acc && in_last && !at_end;
  assign xfer       = fill_full_p0 && (!mat_valid || mat_ready);

  // Stage p0: fill buffer (no reset; contents are only exposed through a transfer)
  always_ff @(posedge clk) begin
    if (acc && !early_last) fill_mem[idx_p0] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p0       <= '0;
      fill_full_p0 <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      // A framing error is any disagreement between in_last and the final slot.
      frame_err <= acc && (in_last != at_end);
      if (acc) idx_p0 <= (in_last || at_end) ? '0 : idx_p0 + 1'b1;
      if (xfer)
        fill_full_p0 <= 1'b0;
      else if (acc && at_end)
        fill_full_p0 <= 1'b1;
    end
  end

  // Stage p1: output register, reloaded only by a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mat_valid <= 1'b0;
      mat_data  <= '0;
    end else begin
      if (xfer)
        mat_valid <= 1'b1;
      else if (mat_ready)
        mat_valid <= 1'b0;
      if (xfer) begin
        for (int r = 0; r < ARRAY_W; r++)
          for (int c = 0; c < ARRAY_L; c++)
            mat_data[r][c] <= fill_mem[r*ARRAY_L + c];
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader (4x4x8): directed table, corner sequences and a randomized run vs. a queue model.
module tb_matrix_loader;
  import systolic_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  matrix_t     mat_data;
  logic        mat_valid;
  logic        mat_ready;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_seen = 0;

  matrix_loader #(.DATA_WIDTH(8), .ARRAY_W(4), .ARRAY_L(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .mat_data(mat_data), .mat_valid(mat_valid), .mat_ready(mat_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of accepted elements, at most one completed frame
  // waiting for the output, and the frame currently offered to the consumer.
  logic [7:0] part_q[$];
  matrix_t    m_pend;
  bit         m_pend_v;
  matrix_t    m_out;
  bit         m_out_v;
  bit         m_err;

  always @(posedge clk or negedge rst_n) begin
    bit take, move;
    if (!rst_n) begin
      part_q.delete();
      m_pend_v = 0;
      m_out    = '0;
      m_out_v  = 0;
      m_err    = 0;
    end else begin
      take  = in_valid && !m_pend_v;
      move  = m_pend_v && (!m_out_v || mat_ready);
      m_err = 0;
      if (mat_ready) m_out_v = 0;
      if (move) begin
        m_out    = m_pend;
        m_out_v  = 1;
        m_pend_v = 0;
      end
      if (take) begin
        part_q.push_back(in_data);
        if (part_q.size() == 16) begin
          for (int k = 0; k < 16; k++) m_pend[k/4][k%4] = part_q[k];
          m_pend_v = 1;
          m_err    = !in_last;
          part_q.delete();
        end else if (in_last) begin
          m_err = 1;
          part_q.delete();
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_in_ready", in_ready, !m_pend_v);
    chk("model_mat_valid", mat_valid, m_out_v);
    chk("model_frame_err", frame_err, m_err);
    chk("model_mat_data", mat_data, m_out);
    if (frame_err) err_seen++;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_in_ready"}, in_ready, 1);
    chk({nm, "_mat_valid"}, mat_valid, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
    chk({nm, "_mat_data"}, mat_data, 0);
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit l, input bit mr);
    in_valid = v; in_data = d; in_last = l; mat_ready = mr;
    @(negedge clk);
    check_model();
  endtask

  task automatic put(input logic [7:0] d, input bit l, input bit mr);
    int b = 0;
    while (!in_ready && b < 64) begin
      cyc(0, 8'h00, 0, mr);
      b++;
    end
    if (!in_ready) chk("put_timeout", in_ready, 1);
    cyc(1, d, l, mr);
  endtask

  task automatic send(input logic [7:0] base, input int n, input bit last, input bit mr);
    for (int i = 0; i < n; i++) put(base + 8'(i), last && (i == n - 1), mr);
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!mat_valid && b < 64) begin
      cyc(0, 8'h00, 0, 0);
      b++;
    end
    chk("wait_valid", mat_valid, 1);
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic l; logic mr;
    logic e_rdy; logic e_mv; logic e_err;
  } vec_t;

  vec_t       tbl[18];
  logic [7:0] gd[16];
  matrix_t    gexp;
  int         cnt;
  bit         rv, rl, racc;

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i].v = 1; tbl[i].d = 8'(i); tbl[i].l = (i == 15); tbl[i].mr = 1;
      tbl[i].e_rdy = (i != 15); tbl[i].e_mv = 0; tbl[i].e_err = 0;
    end
    tbl[16] = '{v:0, d:8'h00, l:0, mr:1, e_rdy:1, e_mv:1, e_err:0};
    tbl[17] = '{v:0, d:8'h00, l:0, mr:1, e_rdy:1, e_mv:0, e_err:0};

    rst_n = 0; in_valid = 0; in_data = 0; in_last = 0; mat_ready = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1;

    // Back-to-back stream 0x00..0x0F
    err_seen = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
      chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_mat_valid", i), mat_valid, tbl[i].e_mv);
      chk($sformatf("tbl%0d_frame_err", i), frame_err, tbl[i].e_err);
      if (i == 16) begin
        chk("b2b_00", mat_data[0][0], 8'h00);
        chk("b2b_12", mat_data[1][2], 8'h06);
        chk("b2b_33", mat_data[3][3], 8'h0F);
      end
    end
    chk("b2b_no_err", err_seen, 0);

    // Output back-pressure: A is held while B fills behind it
    send(8'h10, 16, 1, 0);
    send(8'h20, 16, 1, 0);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_hold_valid", mat_valid, 1);
    repeat (3) cyc(0, 8'h00, 0, 0);
    chk("bp_hold_00", mat_data[0][0], 8'h10);
    chk("bp_hold_33", mat_data[3][3], 8'h1F);
    chk("bp_still_blocked", in_ready, 0);
    cyc(0, 8'h00, 0, 1);
    chk("bp_swap_valid", mat_valid, 1);
    chk("bp_swap_00", mat_data[0][0], 8'h20);
    chk("bp_swap_33", mat_data[3][3], 8'h2F);
    cyc(0, 8'h00, 0, 1);
    chk("bp_drained", mat_valid, 0);

    // Early last on the 5th element, then a clean frame
    err_seen = 0;
    send(8'h60, 5, 1, 0);
    send(8'h30, 16, 1, 0);
    wait_valid();
    chk("early_00", mat_data[0][0], 8'h30);
    chk("early_33", mat_data[3][3], 8'h3F);
    chk("early_err_count", err_seen, 1);
    cyc(0, 8'h00, 0, 1);

    // Missing last: frame still delivered, error pulses right after the 16th accept
    err_seen = 0;
    send(8'h50, 15, 0, 0);
    put(8'h5F, 0, 0);
    chk("miss_err_pulse", frame_err, 1);
    wait_valid();
    chk("miss_00", mat_data[0][0], 8'h50);
    chk("miss_21", mat_data[2][1], 8'h59);
    chk("miss_33", mat_data[3][3], 8'h5F);
    chk("miss_err_count", err_seen, 1);
    cyc(0, 8'h00, 0, 1);

    // Gaps: same random frame with and without idle cycles
    for (int k = 0; k < 16; k++) begin
      gd[k] = 8'($urandom);
      gexp[k/4][k%4] = gd[k];
    end
    for (int k = 0; k < 16; k++) put(gd[k], k == 15, 0);
    wait_valid();
    chk("gapless_frame", mat_data, gexp);
    cyc(0, 8'h00, 0, 1);
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 3)) cyc(0, 8'hEE, 1, 0);
      put(gd[k], k == 15, 0);
    end
    wait_valid();
    chk("gapped_frame", mat_data, gexp);
    cyc(0, 8'h00, 0, 1);

    // Randomized traffic against the model
    cnt = 0;
    for (int t = 0; t < 2000; t++) begin
      rv   = ($urandom_range(0, 3) != 0);
      rl   = (cnt == 15) ^ ($urandom_range(0, 24) == 0);
      racc = rv && in_ready;
      cyc(rv, 8'($urandom), rl, $urandom_range(0, 2) != 0);
      if (racc) cnt = (rl || cnt == 15) ? 0 : cnt + 1;
    end

    // Reset mid-frame
    send(8'h70, 7, 0, 1);
    rst_n = 0;
    #1;
    chk_reset_vals("rst_async");
    cyc(1, 8'hAA, 0, 1);
    chk_reset_vals("rst_hold");
    rst_n = 1;
    send(8'h40, 16, 1, 0);
    wait_valid();
    chk("rst_00", mat_data[0][0], 8'h40);
    chk("rst_33", mat_data[3][3], 8'h4F);
    cyc(0, 8'h00, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
